// File: rtl/controller_pkg.sv
// Shared types and encodings for the multi-cycle rv32i control FSM.
package controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {ALU_ADD = 4'b0000, ALU_SUB = 4'b1000} alu_ctl_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_PLUS_IMM, PC_ALU} pc_src_t;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_src_t;

  // Width selects of LOAD/STORE that exist in RV32I.
  function automatic logic mem_func3_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OPC_LOAD) return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    return f3 <= 3'b010;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from func3 and the ALU compare flags.
module branch_cond (
  input  logic [2:0] func3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the rv32i core,
// with sticky illegal-instruction and memory-stall watchdog flags.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int MAX_WAIT        = 255,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic [3:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] sign_ext_control,
  output logic       reg_write_control,
  output logic [1:0] reg_write_data_source_control,
  output logic       illegal_instr,
  output logic       bus_error,
  output state_t     fsm_state
);

  localparam int WDOG_W = $clog2(MAX_WAIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MAX_WAIT - 1);

  state_t            state, state_next;
  logic [WDOG_W-1:0] wdog;
  logic              br_taken, br_illegal, legal;
  logic              stall, timeout, set_illegal, set_bus_error;

  branch_cond u_branch_cond (
    .func3    (func3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .taken    (br_taken),
    .illegal  (br_illegal)
  );

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
      OPC_LOAD, OPC_STORE: legal = mem_func3_legal(opcode, func3);
      OPC_BRANCH:          legal = !br_illegal;
      default:             legal = 1'b0;
    endcase
  end

  // A ready in the limit cycle is not a stall, so it completes without error.
  assign stall   = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timeout = stall && (wdog == WDOG_LAST);

  always_comb begin
    state_next                    = state;
    imem_req                      = 1'b0;
    ir_write                      = 1'b0;
    dmem_req                      = 1'b0;
    dmem_we                       = 1'b0;
    pc_write                      = 1'b0;
    pc_source                     = PC_PLUS4;
    alu_control                   = ALU_ADD;
    alu_src_a                     = SRC_A_RS1;
    alu_src_b                     = 1'b0;
    sign_ext_control              = IMM_I;
    reg_write_control             = 1'b0;
    reg_write_data_source_control = WB_ALU;
    set_illegal                   = 1'b0;
    set_bus_error                 = 1'b0;

    // The IR is valid from DECODE on; datapath selects hold through WB.
    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (opcode)
        OPC_OP:     begin alu_control = {func7_5, func3}; alu_src_b = 1'b1; end
        OPC_OP_IMM: alu_control = {func7_5 & (func3 == 3'b101), func3};
        OPC_STORE:  sign_ext_control = IMM_S;
        OPC_BRANCH: begin alu_control = ALU_SUB; alu_src_b = 1'b1; sign_ext_control = IMM_B; end
        OPC_LUI:    begin alu_src_a = SRC_A_ZERO; sign_ext_control = IMM_U; end
        OPC_AUIPC:  begin alu_src_a = SRC_A_PC; sign_ext_control = IMM_U; end
        OPC_JAL:    sign_ext_control = IMM_J;
        default:    ;
      endcase
    end

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_next    = S_HALT;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          if (HALT_ON_ILLEGAL) begin
            state_next = S_HALT;
          end else begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_next = S_MEM;
        end else if (opcode == OPC_BRANCH) begin
          pc_write   = 1'b1;
          pc_source  = br_taken ? PC_PLUS_IMM : PC_PLUS4;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_next    = S_HALT;
        end
      end
      S_WB: begin
        reg_write_control = 1'b1;
        pc_write          = 1'b1;
        state_next        = S_FETCH;
        if (opcode == OPC_LOAD) begin
          reg_write_data_source_control = WB_MEM;
        end else if (opcode == OPC_JAL) begin
          reg_write_data_source_control = WB_PC4;
          pc_source                     = PC_PLUS_IMM;
        end else if (opcode == OPC_JALR) begin
          reg_write_data_source_control = WB_PC4;
          pc_source                     = PC_ALU;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase

    // An instruction aborted by reset must not commit anything.
    if (reset) begin
      ir_write          = 1'b0;
      pc_write          = 1'b0;
      reg_write_control = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      wdog          <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= state_next;
      if (stall && (state_next == state)) wdog <= wdog + 1'b1;
      else                                wdog <= '0;
      if (set_illegal)   illegal_instr <= 1'b1;
      if (set_bus_error) bus_error     <= 1'b1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed steps plus random instructions
// checked against an instruction-level model of latency and control effects.
module tb_multicycle_controller;
  import controller_pkg::*;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic [6:0] op_tab [9] = '{T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       func7_5 = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;

  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src_b;
  logic       reg_write_control, illegal_instr, bus_error;
  logic [1:0] pc_source, alu_src_a, reg_write_data_source_control;
  logic [3:0] alu_control;
  logic [2:0] sign_ext_control;
  state_t     fsm_state;

  logic       h_imem_req, h_dmem_req, h_dmem_we, h_ir_write, h_pc_write, h_alu_src_b;
  logic       h_reg_write_control, h_illegal_instr, h_bus_error;
  logic [1:0] h_pc_source, h_alu_src_a, h_reg_write_data_source_control;
  logic [3:0] h_alu_control;
  logic [2:0] h_sign_ext_control;
  state_t     h_fsm_state;

  multicycle_controller #(.MAX_WAIT(4), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .sign_ext_control(sign_ext_control),
    .reg_write_control(reg_write_control),
    .reg_write_data_source_control(reg_write_data_source_control),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .fsm_state(fsm_state)
  );

  multicycle_controller #(.MAX_WAIT(4), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(h_imem_req), .dmem_req(h_dmem_req), .dmem_we(h_dmem_we), .ir_write(h_ir_write),
    .pc_write(h_pc_write), .pc_source(h_pc_source), .alu_control(h_alu_control),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .sign_ext_control(h_sign_ext_control),
    .reg_write_control(h_reg_write_control),
    .reg_write_data_source_control(h_reg_write_data_source_control),
    .illegal_instr(h_illegal_instr), .bus_error(h_bus_error), .fsm_state(h_fsm_state)
  );

  // scoreboard
  int         vectors = 0;
  int         miscompares = 0;
  bit         illegal_seen = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: observed %0h expected <queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // reference model
  function automatic bit legal_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      T_OP, T_OPIMM, T_JAL, T_JALR, T_LUI, T_AUIPC: return 1'b1;
      T_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      T_STORE:  return f3 inside {3'd0, 3'd1, 3'd2};
      T_BRANCH: return !(f3 inside {3'd2, 3'd3});
      default:  return 1'b0;
    endcase
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input logic [2:0] fl);
    case (f3)
      3'd0:    return fl[2];
      3'd1:    return !fl[2];
      3'd4:    return fl[1];
      3'd5:    return !fl[1];
      3'd6:    return fl[0];
      3'd7:    return !fl[0];
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(fsm_state), 32'(S_FETCH));
    chk("rst_illegal", 32'(illegal_instr), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_reg_write", 32'(reg_write_control), 0);
    reset = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 1);
    illegal_seen = 1'b0;
  endtask

  // fl = {alu_zero, alu_lt, alu_ltu}; iw/dw = stall cycles on imem/dmem.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] fl, input int iw, input int dw);
    bit legal, is_load, is_store, is_br, writes, has_alu, has_imm;
    int exp_cyc;
    int cyc, ic, dc, irw, pcw, rw, dreq, dwe, both, wb_cyc, pc_cyc;
    logic [1:0] psrc, rsrc, asa;
    logic [2:0] sext;
    logic [3:0] actl;
    logic       bsrc;
    bit         done;
    cyc = 0; ic = 0; dc = 0; irw = 0; pcw = 0; rw = 0; dreq = 0; dwe = 0; both = 0;
    wb_cyc = -1; pc_cyc = -2; done = 1'b0;
    psrc = '0; rsrc = '0; asa = '0; sext = '0; actl = '0; bsrc = 1'b0;

    legal    = legal_of(op, f3);
    is_load  = legal && (op == T_LOAD);
    is_store = legal && (op == T_STORE);
    is_br    = legal && (op == T_BRANCH);
    writes   = legal && !is_br && !is_store;
    has_alu  = legal && (op inside {T_OP, T_OPIMM, T_BRANCH, T_LUI, T_AUIPC});
    has_imm  = writes && (op != T_OP);
    if (!legal) begin
      exp_cyc = 2 + iw;
      illegal_seen = 1'b1;
    end else if (is_br)    exp_cyc = 3 + iw;
    else if (is_load)      exp_cyc = 5 + iw + dw;
    else if (is_store)     exp_cyc = 4 + iw + dw;
    else                   exp_cyc = 4 + iw;

    expect_val(exp_cyc);
    expect_val(1);
    if (legal && op == T_JALR)                  expect_val(2);
    else if (legal && op == T_JAL)              expect_val(1);
    else if (is_br && taken_of(f3, fl))         expect_val(1);
    else                                        expect_val(0);
    expect_val(1);
    expect_val(32'(writes));
    if (writes) begin
      expect_val(is_load ? 1 : (op == T_JAL || op == T_JALR) ? 2 : 0);
      expect_val(1);
    end
    expect_val((is_load || is_store) ? dw + 1 : 0);
    expect_val(is_store ? dw + 1 : 0);
    expect_val(0);
    if (has_alu) begin
      if (op == T_OP)          expect_val(32'({f7, f3}));
      else if (op == T_OPIMM)  expect_val(32'({f7 & (f3 == 3'd5), f3}));
      else if (is_br)          expect_val(32'h8);
      else                     expect_val(0);
      expect_val((op == T_OP || is_br) ? 1 : 0);
    end
    if (has_imm) begin
      expect_val(op == T_LUI ? 2 : op == T_AUIPC ? 1 : 0);
      expect_val((op == T_LUI || op == T_AUIPC) ? 3 : op == T_JAL ? 4 : 0);
    end
    expect_val(32'(illegal_seen));
    expect_val(0);

    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) begin
        opcode = op; func3 = f3; func7_5 = f7;
        {alu_zero, alu_lt, alu_ltu} = fl;
      end
      imem_ready = imem_req && (ic == iw);
      if (imem_req) ic++;
      dmem_ready = dmem_req && (dc == dw);
      if (dmem_req) dc++;
      #1;
      cyc++;
      if (ir_write) irw++;
      if (dmem_req) dreq++;
      if (dmem_we) dwe++;
      if (reg_write_control && dmem_we) both++;
      if (reg_write_control) begin
        rw++;
        rsrc = reg_write_data_source_control;
        wb_cyc = cyc;
      end
      if (pc_write) begin
        pcw++;
        psrc = pc_source; asa = alu_src_a; sext = sign_ext_control;
        actl = alu_control; bsrc = alu_src_b;
        pc_cyc = cyc;
        done = 1'b1;
      end
    end

    check_next("cycles", cyc);
    check_next("pc_write_count", pcw);
    check_next("pc_source", 32'(psrc));
    check_next("ir_write_count", irw);
    check_next("reg_write_count", rw);
    if (writes) begin
      check_next("wb_source", 32'(rsrc));
      check_next("wb_with_pc_write", 32'(wb_cyc == pc_cyc));
    end
    check_next("dmem_req_cycles", dreq);
    check_next("dmem_we_cycles", dwe);
    check_next("we_and_reg_write", both);
    if (has_alu) begin
      check_next("alu_control", 32'(actl));
      check_next("alu_src_b", 32'(bsrc));
    end
    if (has_imm) begin
      check_next("alu_src_a", 32'(asa));
      check_next("sign_ext", 32'(sext));
    end
    @(posedge clk);
    #1;
    check_next("illegal_flag", 32'(illegal_instr));
    check_next("bus_error_flag", 32'(bus_error));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();

    // illegal opcode: skipped by dut, halts dut_h
    run_instr(7'h7f, 3'd0, 1'b0, 3'd0, 0, 0);
    chk("halt_h_state", 32'(h_fsm_state), 32'(S_HALT));
    chk("halt_h_illegal", 32'(h_illegal_instr), 1);
    chk("halt_h_imem_req", 32'(h_imem_req), 0);
    imem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("halt_h_pc_write", 32'(h_pc_write), 0);
      chk("halt_h_hold", 32'(h_fsm_state), 32'(S_HALT));
    end
    do_reset();

    run_instr(T_OPIMM, 3'd0, 1'b0, 3'd0, 0, 0);   // ADDI
    run_instr(T_LOAD, 3'd2, 1'b0, 3'd0, 0, 3);    // LW, 3-cycle dmem stall
    run_instr(T_BRANCH, 3'd1, 1'b0, 3'd0, 0, 0);  // BNE taken
    run_instr(T_BRANCH, 3'd1, 1'b0, 3'd4, 0, 0);  // BNE not taken
    run_instr(T_JALR, 3'd0, 1'b0, 3'd0, 0, 0);
    run_instr(T_JAL, 3'd0, 1'b0, 3'd0, 1, 0);
    run_instr(T_OPIMM, 3'd5, 1'b1, 3'd0, 0, 0);   // SRAI
    run_instr(T_OPIMM, 3'd1, 1'b1, 3'd0, 0, 0);   // SLLI, func7_5 ignored
    run_instr(T_OP, 3'd0, 1'b1, 3'd0, 2, 0);      // SUB
    run_instr(T_STORE, 3'd2, 1'b0, 3'd0, 3, 3);   // SW, ready on the last allowed cycle
    run_instr(T_LUI, 3'd0, 1'b0, 3'd0, 0, 0);
    run_instr(T_AUIPC, 3'd0, 1'b0, 3'd0, 0, 0);
    run_instr(T_BRANCH, 3'd2, 1'b0, 3'd0, 0, 0);  // illegal branch func3
    run_instr(T_LOAD, 3'd3, 1'b0, 3'd0, 0, 0);    // illegal load width

    // reset during WB suppresses the commit
    opcode = T_OPIMM; func3 = 3'd0; func7_5 = 1'b0;
    repeat (3) begin @(negedge clk); imem_ready = imem_req; end
    @(negedge clk);
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wb_pc_write", 32'(pc_write), 0);
    chk("rst_wb_reg_write", 32'(reg_write_control), 0);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      int k;
      logic [6:0] op;
      k = int'($urandom_range(0, 9));
      op = (k == 9) ? 7'($urandom_range(0, 127)) : op_tab[k];
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // dmem watchdog: 4th stall cycle in MEM times out
    do_reset();
    opcode = T_LOAD; func3 = 3'd2; func7_5 = 1'b0;
    repeat (7) begin @(negedge clk); imem_ready = imem_req; dmem_ready = 1'b0; end
    #1;
    chk("wdog_mem_last_stall_state", 32'(fsm_state), 32'(S_MEM));
    chk("wdog_mem_last_stall_err", 32'(bus_error), 0);
    @(negedge clk); #1;
    chk("wdog_mem_state", 32'(fsm_state), 32'(S_HALT));
    chk("wdog_mem_err", 32'(bus_error), 1);
    chk("wdog_mem_dmem_req", 32'(dmem_req), 0);

    // imem watchdog
    do_reset();
    imem_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("wdog_fetch_last_stall_state", 32'(fsm_state), 32'(S_FETCH));
    chk("wdog_fetch_last_stall_err", 32'(bus_error), 0);
    @(negedge clk); #1;
    chk("wdog_fetch_state", 32'(fsm_state), 32'(S_HALT));
    chk("wdog_fetch_err", 32'(bus_error), 1);
    chk("wdog_fetch_imem_req", 32'(imem_req), 0);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("halt_pc_write", 32'(pc_write), 0);
      chk("halt_ir_write", 32'(ir_write), 0);
      chk("halt_hold", 32'(fsm_state), 32'(S_HALT));
    end
    do_reset();
    run_instr(T_OPIMM, 3'd0, 1'b0, 3'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
